// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - mode-0 SPI master shifting fixed 16-bit frames with a valid/ready parallel side
// Build option: define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master_frame #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  cs_bar,
    output logic                  mosi,
    input  logic                  miso
);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_bar_q, cs_bar_d;
    logic                  mosi_q, mosi_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q, busy_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  div_done;
    logic [FRAME_BITS-1:0] tx_next;
    logic [FRAME_BITS-1:0] rx_next;

    function automatic logic first_bit(input logic [FRAME_BITS-1:0] v);
        return LSB_FIRST ? v[0] : v[FRAME_BITS-1];
    endfunction

    assign div_done = (div_q == DIV_LAST);
    assign tx_next  = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
    assign rx_next  = LSB_FIRST ? {miso, rx_sr_q[FRAME_BITS-1:1]}
                                : {rx_sr_q[FRAME_BITS-2:0], miso};

    always_comb begin
        state_d    = state_q;
        div_d      = div_done ? 8'd0 : div_q + 8'd1;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        cs_bar_d   = cs_bar_q;
        mosi_d     = mosi_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = 8'd0;
                if (tx_start) begin
                    tx_sr_d    = tx_data;
                    mosi_d     = first_bit(tx_data);
                    cs_bar_d   = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    bit_d      = 4'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_done) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = rx_next;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // last falling edge leaves mosi on the final bit through HOLD
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            tx_sr_d = tx_next;
                            mosi_d  = first_bit(tx_next);
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sr_d = rx_next;
                    end
                end
            end
            HOLD: begin
                if (div_done) begin
                    cs_bar_d = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (div_done) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    mosi_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= 4'd0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            cs_bar_q   <= 1'b1;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            cs_bar_q   <= cs_bar_d;
            mosi_q     <= mosi_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign cs_bar   = cs_bar_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_frame.sv
// tb/tb_spi_master_frame.sv - directed bench for spi_master_frame at CLK_DIV=2
// Honours SPI_MASTER_LSB_FIRST_EN for shift direction of the capture and responder models.
module tb_spi_master_frame;
    localparam int D   = 2;
    localparam int LAT = 34 * D + 1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        tx_start = 1'b0;
    logic [15:0] tx_data  = 16'h0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sclk;
    logic        cs_bar;
    logic        mosi;
    logic        miso;

    logic        loop_en   = 1'b1;
    logic [15:0] resp_word = 16'h0;
    logic [15:0] resp_sr   = 16'h0;
    logic        resp_bit;
    logic        sclk_prev = 1'b0;
    logic        cs_prev   = 1'b1;
    logic [15:0] cap       = 16'h0;
    int          rise_cnt  = 0;
    int          vld_cnt   = 0;
    int          cs_bad    = 0;
    int          cyc       = 0;
    int          checks    = 0;
    int          errors    = 0;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
        int          lat;
    } vec_t;
    vec_t vecs[6];

    spi_master_frame #(.CLK_DIV(D), .FRAME_BITS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .cs_bar   (cs_bar),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign resp_bit = LSB ? resp_sr[0] : resp_sr[15];
    assign miso     = loop_en ? mosi : resp_bit;

    // bus monitor and mode-0 responder, sampled mid-cycle
    always @(negedge clk) begin
        sclk_prev <= sclk;
        cs_prev   <= cs_bar;
        if (sclk && !sclk_prev) begin
            rise_cnt <= rise_cnt + 1;
            cap      <= LSB ? {mosi, cap[15:1]} : {cap[14:0], mosi};
        end
        if (cs_bar && !cs_prev && sclk) cs_bad <= cs_bad + 1;
        if (!cs_bar && cs_prev) resp_sr <= resp_word;
        else if (!sclk && sclk_prev && !cs_bar) resp_sr <= LSB ? (resp_sr >> 1) : (resp_sr << 1);
        if (rx_valid) vld_cnt <= vld_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic start(input logic [15:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_start = 1'b1;
        acc      = cyc;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~d;
        chk("cs_low_after_accept", 32'(cs_bar), 32'd0);
        chk("ready_low_after_accept", 32'(tx_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_valid(output int at, output int hi);
        at = -1;
        hi = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cs_bar) hi++;
            if (rx_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL rx_valid_timeout: no pulse within 300 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int acc, t, hi, r0, v0, n;
        int a0, t1, t2, t3, h1, h2, h3;

        vecs[0] = '{tx: 16'hA5C3, rx: 16'hA5C3, lat: LAT};
        vecs[1] = '{tx: 16'h0001, rx: 16'h0001, lat: LAT};
        vecs[2] = '{tx: 16'h8000, rx: 16'h8000, lat: LAT};
        vecs[3] = '{tx: 16'hFFFF, rx: 16'hFFFF, lat: LAT};
        vecs[4] = '{tx: 16'h0000, rx: 16'h0000, lat: LAT};
        vecs[5] = '{tx: 16'h6E19, rx: 16'h6E19, lat: LAT};

        tick(3);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs_bar", 32'(cs_bar), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b1;
        tick(2);

        loop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r0 = rise_cnt;
            start(vecs[i].tx, acc);
            wait_valid(t, hi);
            chk("loop_latency", 32'(t - acc), 32'(vecs[i].lat));
            chk("loop_rx_data", 32'(rx_data), 32'(vecs[i].rx));
            chk("loop_busy_done", 32'(busy), 32'd0);
            tick(1);
            chk("loop_rx_valid_pulse", 32'(rx_valid), 32'd0);
            chk("loop_sclk_rises", 32'(rise_cnt - r0), 32'd16);
            chk("loop_mosi_word", 32'(cap), 32'(vecs[i].tx));
        end

        loop_en   = 1'b0;
        resp_word = 16'h0005;
        r0        = rise_cnt;
        start(16'h0000, acc);
        wait_valid(t, hi);
        chk("resp_rx_data", 32'(rx_data), 32'h0005);
        tick(2);
        chk("resp_sclk_rises", 32'(rise_cnt - r0), 32'd16);
        chk("resp_sclk_low_at_cs_rise", 32'(cs_bad), 32'd0);
        loop_en = 1'b1;

        tick(2);
        tx_data  = 16'h0001;
        tx_start = 1'b1;
        a0       = cyc;
        tick(1);
        tx_data = 16'h0002;
        wait_valid(t1, h1);
        chk("b2b_lat1", 32'(t1 - a0), 32'(LAT));
        chk("b2b_rx1", 32'(rx_data), 32'h0001);
        chk("b2b_cs_gap1", 32'(h1), 32'(D + 1));
        tick(1);
        chk("b2b_restart1", 32'(cs_bar), 32'd0);
        chk("b2b_valid_single1", 32'(rx_valid), 32'd0);
        tx_data = 16'h0003;
        wait_valid(t2, h2);
        chk("b2b_spacing12", 32'(t2 - t1), 32'(LAT));
        chk("b2b_rx2", 32'(rx_data), 32'h0002);
        chk("b2b_cs_gap2", 32'(h2), 32'(D + 1));
        tick(1);
        tx_start = 1'b0;
        chk("b2b_restart2", 32'(cs_bar), 32'd0);
        wait_valid(t3, h3);
        chk("b2b_spacing23", 32'(t3 - t2), 32'(LAT));
        chk("b2b_rx3", 32'(rx_data), 32'h0003);

        tick(2);
        v0 = vld_cnt;
        start(16'h1234, acc);
        tick(20);
        tx_data  = 16'hFFFF;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tx_data  = 16'h0000;
        wait_valid(t, hi);
        chk("busyreq_latency", 32'(t - acc), 32'(LAT));
        chk("busyreq_rx_data", 32'(rx_data), 32'h1234);
        tick(10);
        chk("busyreq_mosi_word", 32'(cap), 32'h1234);
        chk("busyreq_single_valid", 32'(vld_cnt - v0), 32'd1);
        chk("busyreq_idle_cs", 32'(cs_bar), 32'd1);

        r0 = rise_cnt;
        start(16'h5555, acc);
        n = 0;
        while ((rise_cnt - r0) < 7 && n < 100) begin
            tick(1);
            n++;
        end
        chk("midrst_seventh_rise", 32'(rise_cnt - r0), 32'd7);
        v0    = vld_cnt;
        reset = 1'b0;
        #1;
        chk("midrst_cs_bar", 32'(cs_bar), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(80);
        chk("midrst_no_valid", 32'(vld_cnt - v0), 32'd0);
        start(16'hBEEF, acc);
        wait_valid(t, hi);
        chk("postrst_latency", 32'(t - acc), 32'(LAT));
        chk("postrst_rx_data", 32'(rx_data), 32'hBEEF);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master_frame.md
# spi_master_frame

SPI initiator (master) that shifts fixed 16-bit frames out on `mosi` and simultaneously captures 16 bits from `miso`. It generates `sclk` and `cs_bar` from the system clock, so the design can drive external SPI responders such as ADCs or the SPI slave in `uart_spi_top`. It uses mode 0 (CPOL=0, CPHA=0), MSB first by default. A valid/ready handshake on the parallel side lets the UART bridge or a sequencer feed frames back-to-back.

## Interface
Parameters:
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; legal range is 2 to 255.
- `FRAME_BITS`, default 16: bits per frame; fixed at 16 in this release.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  frame request; accepted when `tx_start && tx_ready`.
- `tx_data`  in  16  frame to transmit; captured on acceptance.
- `tx_ready`  out  1  high in IDLE; the block can accept a frame.
- `rx_data`  out  16  last received frame; held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high from acceptance until the return to IDLE.
- `sclk`  out  1  SPI clock; idles low.
- `cs_bar`  out  1  chip select, active low; idles high.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in.

## Operation
- Every output is registered.
- Reset values: `sclk`=0, `cs_bar`=1, `mosi`=0, `tx_ready`=1, `busy`=0, `rx_valid`=0, `rx_data`=0.
- FSM states are IDLE, SETUP, SHIFT, HOLD and GAP. A divider counter counts 0..CLK_DIV-1 and a bit counter counts 0..15.
- **IDLE:** `tx_ready`=1. On acceptance:
  - `tx_data` is loaded into the shift register.
  - `cs_bar` goes to 0, `mosi` takes the first bit, and `busy` goes to 1.
  - The FSM moves to SETUP.
- **SETUP:** lasts CLK_DIV cycles, then `sclk` rises and the FSM moves to SHIFT.
- **SHIFT:** `sclk` toggles every CLK_DIV cycles.
  - On the cycle `sclk` is driven high, `miso` is sampled into the receive shift register.
  - On the cycle `sclk` is driven low, `mosi` advances to the next bit.
  - After the 16th falling edge, `mosi` holds its last value and the FSM moves to HOLD.
- **HOLD:** lasts CLK_DIV cycles, then `cs_bar` goes to 1 and the FSM moves to GAP.
- **GAP:** lasts CLK_DIV cycles. Then:
  - `rx_data` takes the receive shift register and `rx_valid` pulses for one cycle.
  - `tx_ready` goes to 1, `busy` goes to 0, `mosi` goes to 0, and the FSM returns to IDLE.
- `tx_start` is ignored while `tx_ready`=0. No queuing is done.
- `tx_data` changes after acceptance do not affect the frame in flight.
- If `tx_start` is held high, a new frame is accepted on the same cycle `rx_valid` pulses.
- An asserted `reset` mid-frame aborts the frame immediately: all outputs return to their reset values and `rx_valid` does not pulse.
- `miso` is not synchronised. The responder changes it on the falling edge of `sclk`, and CLK_DIV≥2 provides at least one `clk` cycle of setup.

## Timing
- Let D = CLK_DIV and let acceptance be cycle N.
- `tx_ready`=0 and `cs_bar`=0 from cycle N+1.
- The k-th rising edge of `sclk` (k=1..16) is at N+1+(2k−1)·D.
- The k-th falling edge of `sclk` is at N+1+2k·D.
- `cs_bar` returns high at N+1+33·D.
- `rx_valid`, `tx_ready`=1 and `busy`=0 occur at N+1+34·D.
- Latency from acceptance to `rx_valid` is therefore 34·D+1 cycles.
- With back-to-back frames, `cs_bar` stays high for D+1 cycles between frames.
- `rx_valid` is never high on two consecutive cycles.

## Configuration
- Macro: `SPI_MASTER_LSB_FIRST_EN`.
- When defined, transmit and receive are both LSB first: bit 0 goes out first and the first `miso` sample lands in `rx_data[0]`.
- When undefined (the default), both directions are MSB first: bit 15 goes out first and the first sample lands in `rx_data[15]`.
- Cycle timing is identical in both builds.

## Test plan
- **Loopback:** D=2, `miso` tied to `mosi`, `tx_data`=16'hA5C3 → `rx_data`=16'hA5C3, with `rx_valid` exactly 69 cycles after acceptance.
- **Responder model:** a model shifts 16'h0005 on the falling edge of `sclk` while `tx_data`=16'h0000 → `rx_data`=16'h0005. Also check:
  - exactly 16 rising edges on `sclk`;
  - `sclk` is low whenever `cs_bar` goes high.
- **Back-to-back:** `tx_start` held high for three frames 16'h0001, 16'h0002, 16'h0003 → three `rx_valid` pulses spaced 69 cycles apart (D=2), with `cs_bar` high for 3 cycles between frames.
- **Busy-period request:** pulse `tx_start` with 16'hFFFF mid-frame during a 16'h1234 transfer → the pulse is ignored, `mosi` carries only 16'h1234, and only one `rx_valid` occurs.
- **Reset mid-frame:** assert `reset` after the 7th rising edge of `sclk` → on the same cycle `cs_bar`=1, `sclk`=0, `tx_ready`=1 and `rx_data`=0. After release, a 16'hBEEF loopback frame completes correctly.
- **LSB-first build:** with `SPI_MASTER_LSB_FIRST_EN` defined, `tx_data`=16'h0001 → `mosi` is high only during the first bit. In loopback, `rx_data`=16'h0001.
